pulse_wave_generator: RTL and testbench

PULSE_WAVE_GENERATOR -- requirements
Module: pulse_wave_generator

---
 rtl/pulse_wave_generator.sv | 128 ++++++++++++
 tb/tb_pulse_wave_generator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_wave_generator.sv
// ---------------------------------------------------------------------------------------------
// pulse_wave_generator
//
// Pulse / square wave oscillator with glitch-free parameter updates. The requested period,
// duty, amplitude and mode are captured into shadow registers only while the block is idle
// (shadow period < 2) or at the last cycle of a period, so changes made mid-period take
// effect cleanly at the next period boundary.
//
// Optional feature: define PULSE_WAVE_SYNC_EN to add the hard-sync input "sync", which
// restarts the period (cnt -> 0) and reloads the shadows regardless of ena.
//
// Parameters
//   N             width of the period counter, pitch_ticks and duty_ticks
//   W             width of amplitude and out
//
// Ports
//   clk           system clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   sync          hard sync (only with PULSE_WAVE_SYNC_EN)
//   ena           enable; low pauses the oscillator and silences the output
//   mode          0 = PWM using duty_ticks, 1 = 50% square (duty_ticks ignored)
//   pitch_ticks   requested period in clk cycles
//   duty_ticks    requested high time in clk cycles (mode 0 only)
//   amplitude     level driven on out during the high phase
//   out           waveform sample: amplitude or 0
//   period_start  one-cycle strobe on the first cycle of every period
// ---------------------------------------------------------------------------------------------
module pulse_wave_generator #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
`ifdef PULSE_WAVE_SYNC_EN
  input  logic         sync,
`endif
  input  logic         ena,
  input  logic         mode,
  input  logic [N-1:0] pitch_ticks,
  input  logic [N-1:0] duty_ticks,
  input  logic [W-1:0] amplitude,
  output logic [W-1:0] out,
  output logic         period_start
);

  localparam logic [N-1:0] CntOne = N'(1);

  // Period counter and shadow registers
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] per_q, per_d;
  logic [N-1:0] duty_q, duty_d;
  logic [W-1:0] amp_q, amp_d;
  logic         mode_q, mode_d;

  // Control decode
  logic         active;    // shadow period >= 2
  logic         run;       // active and enabled: counter advances, output may be driven
  logic         at_last;   // counter sits on the final cycle of the period
  logic         wrap;      // period boundary this edge
  logic         sync_hit;  // hard sync requested this edge
  logic         load;      // shadows capture the inputs this edge
  logic [N-1:0] deff;      // effective high time

`ifdef PULSE_WAVE_SYNC_EN
  assign sync_hit = sync;
`else
  assign sync_hit = 1'b0;
`endif

  always_comb begin
    active  = (per_q > CntOne);
    run     = active && ena;
    at_last = (cnt_q == (per_q - CntOne));
    wrap    = run && at_last;
    // An inactive block keeps sampling so the first usable setting is picked up at once.
    load    = !active || wrap || sync_hit;
  end

  // Counter next state. A sync coinciding with a wrap yields the same cnt=0 and reload,
  // so the two cases are indistinguishable.
  always_comb begin
    cnt_d = cnt_q;
    if (sync_hit || !active) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = at_last ? '0 : (cnt_q + CntOne);
    end
  end

  always_comb begin
    per_d  = per_q;
    duty_d = duty_q;
    amp_d  = amp_q;
    mode_d = mode_q;
    if (load) begin
      per_d  = pitch_ticks;
      duty_d = duty_ticks;
      amp_d  = amplitude;
      mode_d = mode;
    end
  end

  // Reset has priority over sync and ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      per_q  <= '0;
      duty_q <= '0;
      amp_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      duty_q <= duty_d;
      amp_q  <= amp_d;
      mode_q <= mode_d;
    end
  end

  // Outputs depend only on registered state plus ena. Because cnt never reaches per_q,
  // deff >= per_q naturally gives a constant-high output and deff = 0 a constant-low one.
  always_comb begin
    deff         = mode_q ? (per_q >> 1) : duty_q;
    out          = (run && (cnt_q < deff)) ? amp_q : '0;
    period_start = run && (cnt_q == '0);
  end

endmodule

// File: tb/tb_pulse_wave_generator.sv
// ---------------------------------------------------------------------------------------------
// tb_pulse_wave_generator
//
// Directed testbench for pulse_wave_generator (N=8, W=4). Expected values for out and
// period_start are derived from the position within the current period.
// ---------------------------------------------------------------------------------------------
module tb_pulse_wave_generator;

  localparam int unsigned N = 8;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         mode;
  logic [N-1:0] pitch_ticks;
  logic [N-1:0] duty_ticks;
  logic [W-1:0] amplitude;
  logic [W-1:0] out;
  logic         period_start;
`ifdef PULSE_WAVE_SYNC_EN
  logic         sync;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pulse_wave_generator #(
    .N(N),
    .W(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef PULSE_WAVE_SYNC_EN
    .sync        (sync),
`endif
    .ena         (ena),
    .mode        (mode),
    .pitch_ticks (pitch_ticks),
    .duty_ticks  (duty_ticks),
    .amplitude   (amplitude),
    .out         (out),
    .period_start(period_start)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check cycles c0..c1 of a period of length per with high time hi at level amp.
  task automatic run_span(input string tag, input int per, input int hi, input int amp,
                          input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      #1;
      check_eq({tag, "_out"}, 32'(out), (c < hi && c < per) ? amp : 0);
      check_eq({tag, "_ps"}, 32'(period_start), (c == 0) ? 1 : 0);
      tick();
    end
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      #1;
      check_eq({tag, "_out"}, 32'(out), 0);
      check_eq({tag, "_ps"}, 32'(period_start), 0);
      tick();
    end
  endtask

  initial begin
    rst         = 1'b1;
    ena         = 1'b1;
    mode        = 1'b0;
    pitch_ticks = 8'd10;
    duty_ticks  = 8'd3;
    amplitude   = 4'd5;
`ifdef PULSE_WAVE_SYNC_EN
    sync        = 1'b0;
`endif

    // Reset state
    tick();
    tick();
    check_idle("reset", 2);
    rst = 1'b0;
    // Cycle after release: shadows still zero, block inactive
    #1;
    check_eq("post_rst_out", 32'(out), 0);
    check_eq("post_rst_ps", 32'(period_start), 0);
    tick();

    // PWM pitch 10 duty 3: 5,5,5 then 0 x7
    run_span("pwm", 10, 3, 5, 0, 9);
    run_span("pwm", 10, 3, 5, 0, 9);

    // Mid-period input changes do not affect the current period
    mode       = 1'b1;
    duty_ticks = 8'd7;
    run_span("hold", 10, 3, 5, 0, 9);

    // Square pitch 10 (high 5); pitch changed to 6 at cnt=4
    run_span("sq10", 10, 5, 5, 0, 3);
    pitch_ticks = 8'd6;
    run_span("sq10", 10, 5, 5, 4, 9);
    run_span("sq6", 6, 3, 5, 0, 5);
    run_span("sq6", 6, 3, 5, 0, 5);

    // duty 0 then duty 12 at pitch 10
    mode        = 1'b0;
    duty_ticks  = 8'd0;
    pitch_ticks = 8'd10;
    run_span("sq6b", 6, 3, 5, 0, 5);
    duty_ticks = 8'd12;
    run_span("duty0", 10, 0, 5, 0, 9);
    run_span("dfull", 10, 10, 5, 0, 9);
    duty_ticks = 8'd9;
    run_span("dfull", 10, 10, 5, 0, 9);

    // Pause at cnt=7 for 4 cycles; amplitude change during pause must wait for the wrap
    run_span("pre", 10, 9, 5, 0, 6);
    ena       = 1'b0;
    amplitude = 4'd9;
    check_idle("pause", 4);
    ena = 1'b1;
    run_span("resume", 10, 9, 5, 7, 9);
    pitch_ticks = 8'd1;
    run_span("amp9", 10, 9, 9, 0, 9);

    // pitch 1 then 0: inactive
    pitch_ticks = 8'd0;
    check_idle("p1", 1);
    check_idle("p0", 2);
    pitch_ticks = 8'd4;
    duty_ticks  = 8'd2;
    amplitude   = 4'd3;
    check_idle("p0_load", 1);
    run_span("p4", 4, 2, 3, 0, 3);
    run_span("p4", 4, 2, 3, 0, 3);

    // Reset mid-period aborts the period
    run_span("p4_pre", 4, 2, 3, 0, 1);
    rst = 1'b1;
    tick();
    check_idle("rst_mid", 1);
    rst = 1'b0;
    check_idle("rst_rel", 1);
    run_span("p4_again", 4, 2, 3, 0, 3);

    // Maximum pitch 2**N-1
    pitch_ticks = 8'd255;
    duty_ticks  = 8'd254;
    run_span("p4_last", 4, 2, 3, 0, 3);
    pitch_ticks = 8'd2;
    mode        = 1'b1;
    run_span("p255", 255, 254, 3, 0, 254);
    // Smallest active period, square: 1 high, 1 low
    run_span("p2", 2, 1, 3, 0, 1);
    run_span("p2", 2, 1, 3, 0, 1);

`ifdef PULSE_WAVE_SYNC_EN
    pitch_ticks = 8'd10;
    duty_ticks  = 8'd3;
    amplitude   = 4'd5;
    mode        = 1'b0;
    run_span("p2_last", 2, 1, 3, 0, 1);
    run_span("sync_pre", 10, 3, 5, 0, 5);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    run_span("sync_post", 10, 3, 5, 0, 9);
    // Sync while paused still restarts the period
    run_span("sync_pre2", 10, 3, 5, 0, 4);
    ena  = 1'b0;
    sync = 1'b1;
    tick();
    sync = 1'b0;
    ena  = 1'b1;
    run_span("sync_paused", 10, 3, 5, 0, 9);
    // Reset wins over sync
    run_span("sync_pre3", 10, 3, 5, 0, 3);
    rst  = 1'b1;
    sync = 1'b1;
    tick();
    check_idle("rst_sync", 1);
    rst  = 1'b0;
    sync = 1'b0;
    check_idle("rst_sync_rel", 1);
    run_span("after_rst_sync", 10, 3, 5, 0, 9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
